// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions: address/instruction widths, opcode constants,
// fetch FSM encoding and the buffered fetch entry layout.
package fetch_sequencer_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 8;

  localparam logic [OPC_W-1:0] OPC_NOP    = 8'h00;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 8'h10;
  localparam logic [OPC_W-1:0] OPC_JUMP   = 8'h11;
  localparam logic [OPC_W-1:0] OPC_RET    = 8'h12;
  localparam logic [OPC_W-1:0] OPC_WAIT   = 8'h7F;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic addr_t align_word(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [OPC_W-1:0] opcode_of(input instr_t i);
    return i[OPC_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_sequencer_fifo.sv
// First-word-fall-through buffer with flush; zero-latency head, push accepted
// when not full or when popping in the same cycle, flush overrides push.
module fetch_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer, one request outstanding; words reach decode the
// cycle after the response; fetching stalls when the buffer has no free slot.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [INSTR_W-1:0]  mem_rdata_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  input  logic                halt_i,
  output logic                instr_valid_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]   instr_pc_o,
  input  logic                instr_ready_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  addr_t            fetch_pc_q, fetch_pc_d;
  addr_t            req_pc_q, req_pc_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_after;
  logic             can_req;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign mem_req_o     = (state_q == REQ);
  assign mem_addr_o    = fetch_pc_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;
  assign push_entry    = '{pc: req_pc_q, instr: mem_rdata_i};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    fifo_pop   = instr_valid_o && instr_ready_i;
    fifo_push  = (state_q == WAIT) && mem_rvalid_i && !redirect_i &&
                 (!fifo_full || fifo_pop);
    // Slot accounting is done on next-cycle occupancy so a request is only
    // launched when its response is guaranteed a place to land.
    count_after = redirect_i ? '0 :
                  fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    can_req     = !halt_i && (count_after < CNT_W'(FIFO_DEPTH));

    case (state_q)
      IDLE: begin
        if (can_req) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt_i) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 64'd4;
          state_d    = redirect_i ? DROP : WAIT;
        end
      end
      WAIT: begin
        // A response coinciding with a redirect closes the transaction and is
        // discarded here; waiting in DROP would wait for a word never sent.
        if (mem_rvalid_i)    state_d = can_req ? REQ : IDLE;
        else if (redirect_i) state_d = DROP;
      end
      DROP: begin
        if (mem_rvalid_i) state_d = can_req ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_i) fetch_pc_d = align_word(redirect_pc_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= align_word(RESET_PC);
      req_pc_q   <= align_word(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (push_entry),
    .pop_i      (fifo_pop),
    .flush_i    (redirect_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .head_o     (head_entry)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory responder, delivery scoreboard,
// plus a second instance for address wrap-around.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        halt_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_ready_i;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_ivalid;
  logic [31:0] w_instr;
  logic [63:0] w_ipc;
  logic        w_gnt    = 1'b1;
  logic        w_rvalid = 1'b1;
  logic [31:0] w_rdata  = 32'hCAFE_0013;
  logic        w_redir  = 1'b0;
  logic [63:0] w_rpc    = 64'h0;
  logic        w_halt   = 1'b0;
  logic        w_ready  = 1'b1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] exp_q [$];

  int          lat   = 1;
  int          stall = 0;
  logic        pend;
  int          lat_cnt;
  logic [63:0] pend_addr;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(64'h1000), .FIFO_DEPTH(2)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .mem_req_o     (w_req),
    .mem_addr_o    (w_addr),
    .mem_gnt_i     (w_gnt),
    .mem_rvalid_i  (w_rvalid),
    .mem_rdata_i   (w_rdata),
    .redirect_i    (w_redir),
    .redirect_pc_i (w_rpc),
    .halt_i        (w_halt),
    .instr_valid_o (w_ivalid),
    .instr_o       (w_instr),
    .instr_pc_o    (w_ipc),
    .instr_ready_i (w_ready)
  );

  function automatic logic [31:0] word_of(input logic [63:0] pc);
    return {pc[15:0], pc[7:0] ^ 8'h5A, 8'h13};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int i = 0; i < budget && !mem_req_o; i++) step();
    check(tag, 64'(mem_req_o), 64'd1);
  endtask

  task automatic wait_gnt(input string tag, input int budget);
    for (int i = 0; i < budget && !mem_gnt_i; i++) step();
    check(tag, 64'(mem_gnt_i), 64'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    instr_ready_i = 1'b0;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic settle(input logic [63:0] base);
    halt_i        = 1'b1;
    instr_ready_i = 1'b0;
    repeat (8) step();
    lat   = 1;
    stall = 0;
    redirect_i    = 1'b1;
    redirect_pc_i = base;
    step();
    redirect_i = 1'b0;
    step();
    step();
  endtask

  // Memory model: grants at the negedge preceding the accepting rising edge,
  // answers lat cycles after the grant.
  initial begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    pend         = 1'b0;
    lat_cnt      = 0;
    pend_addr    = '0;
    forever begin
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (lat_cnt <= 1) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = word_of(pend_addr);
            pend         = 1'b0;
          end else begin
            lat_cnt--;
          end
        end
        if (mem_req_o) begin
          if (stall > 0) begin
            stall--;
          end else begin
            mem_gnt_i = 1'b1;
            pend      = 1'b1;
            pend_addr = mem_addr_o;
            lat_cnt   = lat;
          end
        end
      end
    end
  end

  // Delivery scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instr_valid_o && instr_ready_i) begin
        check("deliv_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("deliv_pc", instr_pc_o, e);
          check("deliv_instr", 64'(instr_o), 64'(word_of(e)));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_seen;
    rst           = 1'b1;
    halt_i        = 1'b0;
    instr_ready_i = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;

    repeat (3) step();
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_valid", 64'(instr_valid_o), 64'd0);
    check("rst_addr", mem_addr_o, 64'h1000);
    check("rst_wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Sequential fetch from reset; wrap instance runs alongside.
    exp_q.push_back(64'h1000);
    exp_q.push_back(64'h1004);
    exp_q.push_back(64'h1008);
    rst = 1'b0;
    step();
    check("first_req", 64'(mem_req_o), 64'd1);
    check("first_addr", mem_addr_o, 64'h1000);
    check("wrap_first_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wrap_wait_noreq", 64'(w_req), 64'd0);
    step();
    check("wrap_second_req", 64'(w_req), 64'd1);
    check("wrap_second_addr", w_addr, 64'h0);
    check("wrap_deliv_pc", w_ipc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_deliv_instr", 64'(w_instr), 64'hCAFE_0013);
    drain("seq_drain", 40);

    // Backpressure: exactly two words buffered, no request, then resume.
    settle(64'h3000);
    halt_i   = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 10 && mem_req_o) req_seen++;
    end
    check("bp_no_req", 64'(req_seen), 64'd0);
    check("bp_valid", 64'(instr_valid_o), 64'd1);
    check("bp_head_pc", instr_pc_o, 64'h3000);
    check("bp_count", 64'(u_dut.u_fifo.count_o), 64'd2);
    exp_q.push_back(64'h3000);
    exp_q.push_back(64'h3004);
    exp_q.push_back(64'h3008);
    exp_q.push_back(64'h300C);
    instr_ready_i = 1'b1;
    drain("bp_drain", 60);

    // Redirect while waiting: stale 4000 dropped, restart at 2000.
    settle(64'h4000);
    lat           = 4;
    instr_ready_i = 1'b1;
    exp_q.push_back(64'h2000);
    exp_q.push_back(64'h2004);
    halt_i = 1'b0;
    wait_gnt("redir_gnt", 10);
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h2002;
    step();
    redirect_i = 1'b0;
    check("redir_valid_low", 64'(instr_valid_o), 64'd0);
    wait_req("redir_req", 20);
    check("redir_addr", mem_addr_o, 64'h2000);
    drain("redir_drain", 80);

    // Grant stall: address held, then redirected mid-stall.
    settle(64'h5000);
    stall         = 8;
    instr_ready_i = 1'b1;
    exp_q.push_back(64'h6000);
    exp_q.push_back(64'h6004);
    halt_i = 1'b0;
    wait_req("stall_req", 10);
    for (int i = 0; i < 5; i++) begin
      check("stall_req_held", 64'(mem_req_o), 64'd1);
      check("stall_addr", mem_addr_o, 64'h5000);
      if (i < 4) step();
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h6003;
    step();
    redirect_i = 1'b0;
    check("stall_redir_req", 64'(mem_req_o), 64'd1);
    check("stall_redir_addr", mem_addr_o, 64'h6000);
    drain("stall_drain", 60);

    // Pop and redirect together: popped word delivered, buffer flushed.
    settle(64'h8000);
    halt_i = 1'b0;
    repeat (10) step();
    halt_i = 1'b1;
    check("pr_full_valid", 64'(instr_valid_o), 64'd1);
    exp_q.push_back(64'h8000);
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h9000;
    step();
    redirect_i = 1'b0;
    check("pr_flush_valid", 64'(instr_valid_o), 64'd0);
    check("pr_popped", 64'(exp_q.size()), 64'd0);
    exp_q.push_back(64'h9000);
    exp_q.push_back(64'h9004);
    halt_i = 1'b0;
    drain("pr_drain", 40);

    // Halt during an outstanding fetch.
    settle(64'h7000);
    lat           = 4;
    instr_ready_i = 1'b1;
    exp_q.push_back(64'h7000);
    halt_i = 1'b0;
    wait_gnt("halt_gnt", 10);
    step();
    halt_i   = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (mem_req_o) req_seen++;
    end
    check("halt_no_req", 64'(req_seen), 64'd0);
    check("halt_delivered", 64'(exp_q.size()), 64'd0);
    instr_ready_i = 1'b0;
    halt_i        = 1'b0;
    wait_req("halt_resume_req", 5);
    check("halt_resume_addr", mem_addr_o, 64'h7004);

    // Asynchronous reset between clock edges.
    #1;
    rst = 1'b1;
    #1;
    check("arst_req", 64'(mem_req_o), 64'd0);
    check("arst_valid", 64'(instr_valid_o), 64'd0);
    check("arst_addr", mem_addr_o, 64'h1000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
